// File: rtl/d_cache_writeback_if.sv
// Signal bundle between the writeback engine, its requester, the data RAM read port and memory.
// The engine side uses the master modport; the cache/memory side uses the slave modport.
interface d_cache_writeback_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 3
);
    logic                        wb_req;
    logic [INDEX_W-1:0]          wb_idx;
    logic [TAG_W-1:0]            wb_tag;
    logic                        wb_busy;
    logic                        wb_done;
    logic                        wb_err;

    logic                        ram_sel;
    logic [INDEX_W+OFFSET_W-1:0] ram_addr;
    logic [63:0]                 ram_data;

    logic                        mem_aw_valid;
    logic                        mem_aw_ready;
    logic [ADDR_W-1:0]           mem_aw_addr;
    logic [7:0]                  mem_aw_len;
    logic                        mem_w_valid;
    logic                        mem_w_ready;
    logic [63:0]                 mem_w_data;
    logic [7:0]                  mem_w_strb;
    logic                        mem_w_last;
    logic                        mem_b_valid;
    logic                        mem_b_ready;
    logic [1:0]                  mem_b_resp;

    modport master (
        input  wb_req, wb_idx, wb_tag,
        output wb_busy, wb_done, wb_err,
        output ram_sel, ram_addr,
        input  ram_data,
        output mem_aw_valid, mem_aw_addr, mem_aw_len,
        input  mem_aw_ready,
        output mem_w_valid, mem_w_data, mem_w_strb, mem_w_last,
        input  mem_w_ready,
        input  mem_b_valid, mem_b_resp,
        output mem_b_ready
    );

    modport slave (
        output wb_req, wb_idx, wb_tag,
        input  wb_busy, wb_done, wb_err,
        input  ram_sel, ram_addr,
        output ram_data,
        input  mem_aw_valid, mem_aw_addr, mem_aw_len,
        output mem_aw_ready,
        input  mem_w_valid, mem_w_data, mem_w_strb, mem_w_last,
        output mem_w_ready,
        output mem_b_valid, mem_b_resp,
        input  mem_b_ready
    );
endinterface

// File: rtl/d_cache_writeback.sv
// Dirty-line writeback engine: reads a victim line from the d-cache data RAM into a local
// buffer, then sends it to memory as one address phase, a fixed burst and a write response.
module d_cache_writeback #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 3
) (
    input  logic                 clk,
    input  logic                 rst,
    d_cache_writeback_if.master  bus
);
    localparam int unsigned LINE_WORDS = 1 << OFFSET_W;
    localparam int unsigned CNT_W      = OFFSET_W + 1;
    localparam int unsigned RAM_AW     = INDEX_W + OFFSET_W;
    localparam int unsigned LOW_W      = OFFSET_W + 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        AW   = 3'd2,
        W    = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [63:0]         line_q [LINE_WORDS];
    logic [63:0]         line_d [LINE_WORDS];
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wb_err_q, wb_err_d;
    logic                ram_sel_q, ram_sel_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                w_last_q, w_last_d;
    logic [63:0]         w_data_q, w_data_d;
    logic                b_ready_q, b_ready_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rd_cnt_q   <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            aw_addr_q  <= '0;
            ram_addr_q <= '0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_err_q   <= 1'b0;
            ram_sel_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            w_data_q   <= '0;
            b_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            aw_addr_q  <= aw_addr_d;
            ram_addr_q <= ram_addr_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wb_err_q   <= wb_err_d;
            ram_sel_q  <= ram_sel_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            w_last_q   <= w_last_d;
            w_data_q   <= w_data_d;
            b_ready_q  <= b_ready_d;
        end
    end

    // Next state; outputs are derived from the next state so they are registered yet aligned
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_cnt_d   = rd_cnt_q;
        beat_d     = beat_q;
        err_d      = err_q;
        aw_addr_d  = aw_addr_q;
        ram_addr_d = ram_addr_q;
        line_d     = line_q;

        unique case (state_q)
            IDLE: begin
                if (bus.wb_req) begin
                    state_d    = READ;
                    idx_d      = bus.wb_idx;
                    rd_cnt_d   = '0;
                    err_d      = 1'b0;
                    aw_addr_d  = {bus.wb_tag, bus.wb_idx, LOW_W'(0)};
                    ram_addr_d = {bus.wb_idx, OFFSET_W'(0)};
                end
            end
            READ: begin
                // RAM data lags the address by one cycle, so capture trails the counter
                if (rd_cnt_q != '0) begin
                    line_d[OFFSET_W'(rd_cnt_q - CNT_W'(1))] = bus.ram_data;
                end
                if (rd_cnt_q == CNT_W'(LINE_WORDS)) begin
                    state_d = AW;
                end else begin
                    rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                    ram_addr_d = {idx_q, OFFSET_W'(rd_cnt_q + CNT_W'(1))};
                end
            end
            AW: begin
                if (bus.mem_aw_ready) begin
                    state_d = W;
                    beat_d  = '0;
                end
            end
            W: begin
                if (bus.mem_w_ready) begin
                    if (beat_q == OFFSET_W'(LINE_WORDS - 1)) begin
                        state_d = B;
                    end else begin
                        beat_d = beat_q + OFFSET_W'(1);
                    end
                end
            end
            B: begin
                if (bus.mem_b_valid) begin
                    err_d   = (bus.mem_b_resp != 2'b00);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        wb_err_d   = (state_d == DONE) && err_d;
        ram_sel_d  = (state_d == READ);
        aw_valid_d = (state_d == AW);
        w_valid_d  = (state_d == W);
        w_last_d   = (state_d == W) && (beat_d == OFFSET_W'(LINE_WORDS - 1));
        w_data_d   = line_q[beat_d];
        b_ready_d  = (state_d == B);
    end

    assign bus.wb_busy      = busy_q;
    assign bus.wb_done      = done_q;
    assign bus.wb_err       = wb_err_q;
    assign bus.ram_sel      = ram_sel_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.mem_aw_valid = aw_valid_q;
    assign bus.mem_aw_addr  = aw_addr_q;
    assign bus.mem_aw_len   = 8'(LINE_WORDS - 1);
    assign bus.mem_w_valid  = w_valid_q;
    assign bus.mem_w_data   = w_data_q;
    assign bus.mem_w_strb   = 8'hFF;
    assign bus.mem_w_last   = w_last_q;
    assign bus.mem_b_ready  = b_ready_q;
endmodule
